// File: rtl/cle_tag_lookup_pkg.sv
// Shared geometry constants and helpers for the cle tag-lookup stage.
// Widths follow the miss-status FIFO interface this stage feeds.
package cle_tag_lookup_pkg;

  localparam int LINE_ADDR_W    = 27;
  localparam int SCB_ID_W       = 2;
  localparam int WARP_ID_W      = 3;
  localparam int LAT_W          = 5;
  localparam int PERF_W         = 16;
  localparam int OUTST_W        = 4;

  localparam int SETS_DEF       = 64;
  localparam int MSHR_DEPTH_DEF = 8;
  localparam logic [LAT_W-1:0] MISS_LAT_DEF = 5'd20;

  // Perf counters stick at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cle_tag_lookup_if.sv
// Request, lookup-result and miss-return signals between the load pipe,
// this lookup stage and the miss-status FIFO.
interface cle_tag_lookup_if;
  import cle_tag_lookup_pkg::*;

  logic                   req_valid;
  logic                   req_ready;
  logic [LINE_ADDR_W-1:0] req_addr;
  logic [SCB_ID_W-1:0]    req_scbID;
  logic [WARP_ID_W-1:0]   req_warpID;

  logic                   cle_hit_missbar;
  logic [LINE_ADDR_W-1:0] cle_addr;
  logic [LAT_W-1:0]       cle_latency;
  logic [SCB_ID_W-1:0]    scbID;
  logic [WARP_ID_W-1:0]   warpID;
  logic                   addr_valid;

  logic                   neg_feedback_valid;
  logic [LINE_ADDR_W-1:0] neg_feedback_addr;

  modport master (
    output req_valid, req_addr, req_scbID, req_warpID,
    output neg_feedback_valid, neg_feedback_addr,
    input  req_ready, cle_hit_missbar, cle_addr, cle_latency, scbID, warpID, addr_valid
  );

  modport slave (
    input  req_valid, req_addr, req_scbID, req_warpID,
    input  neg_feedback_valid, neg_feedback_addr,
    output req_ready, cle_hit_missbar, cle_addr, cle_latency, scbID, warpID, addr_valid
  );

endinterface

// File: rtl/cle_tag_array.sv
// Direct-mapped valid+tag store: combinational read, synchronous write,
// synchronous clear of all valid bits.
module cle_tag_array
  import cle_tag_lookup_pkg::*;
#(
  parameter  int SETS    = SETS_DEF,
  localparam int INDEX_W = $clog2(SETS),
  localparam int TAG_W   = LINE_ADDR_W - INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tags need no reset; a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index] <= wr_tag;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];

endmodule

// File: rtl/cle_tag_lookup.sv
// Direct-mapped tag lookup ahead of the miss-status FIFO: resolves hit/miss,
// fills on miss return and throttles requests so the FIFO cannot overflow.
module cle_tag_lookup
  import cle_tag_lookup_pkg::*;
#(
  parameter int               SETS       = SETS_DEF,
  parameter int               MSHR_DEPTH = MSHR_DEPTH_DEF,
  parameter logic [LAT_W-1:0] MISS_LAT   = MISS_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  cle_tag_lookup_if.slave     bus,
  output logic [PERF_W-1:0]   hit_count,
  output logic [PERF_W-1:0]   miss_count
);

  localparam int INDEX_W = $clog2(SETS);
  localparam int TAG_W   = LINE_ADDR_W - INDEX_W;

  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] fb_index;
  logic [TAG_W-1:0]   fb_tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic               hit;
  logic               accept;
  logic               miss_acc;
  logic [OUTST_W-1:0] outstanding_q;
  logic [OUTST_W-1:0] outstanding_d;

  assign req_index = bus.req_addr[INDEX_W-1:0];
  assign req_tag   = bus.req_addr[LINE_ADDR_W-1:INDEX_W];
  assign fb_index  = bus.neg_feedback_addr[INDEX_W-1:0];
  assign fb_tag    = bus.neg_feedback_addr[LINE_ADDR_W-1:INDEX_W];

  cle_tag_array #(.SETS(SETS)) u_tag_array (
    .clk      (clk),
    .rst      (rst),
    .rd_index (req_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .wr_en    (bus.neg_feedback_valid),
    .wr_index (fb_index),
    .wr_tag   (fb_tag)
  );

  // Read port sees pre-edge contents, so a same-edge fill cannot turn a miss into a hit.
  assign hit           = rd_valid && (rd_tag == req_tag);
  assign bus.req_ready = (outstanding_q != OUTST_W'(MSHR_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign miss_acc      = accept && !hit;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({miss_acc, bus.neg_feedback_valid})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding_q <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      if (accept && hit)  hit_count  <= sat_inc(hit_count);
      if (miss_acc)       miss_count <= sat_inc(miss_count);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.addr_valid      <= 1'b0;
      bus.cle_hit_missbar <= 1'b0;
      bus.cle_latency     <= '0;
      bus.cle_addr        <= '0;
      bus.scbID           <= '0;
      bus.warpID          <= '0;
    end else begin
      bus.addr_valid <= accept;
      if (accept) begin
        bus.cle_hit_missbar <= hit;
        bus.cle_latency     <= hit ? '0 : MISS_LAT;
        bus.cle_addr        <= bus.req_addr;
        bus.scbID           <= bus.req_scbID;
        bus.warpID          <= bus.req_warpID;
      end
    end
  end

  // A miss return with nothing outstanding means the FIFO and this stage disagree.
  a_fb_underflow: assert property (@(posedge clk) disable iff (rst)
    !(bus.neg_feedback_valid && !miss_acc && (outstanding_q == '0)));

endmodule

// File: tb/tb_cle_tag_lookup.sv
// Directed + randomized bench for cle_tag_lookup against a set-indexed
// line-address model with an outstanding-miss count.
module tb_cle_tag_lookup;
  import cle_tag_lookup_pkg::*;

  localparam int NSETS = 64;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [PERF_W-1:0] hit_count;
  logic [PERF_W-1:0] miss_count;

  cle_tag_lookup_if bus();

  cle_tag_lookup #(.SETS(NSETS), .MSHR_DEPTH(DEPTH), .MISS_LAT(5'd20)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  // Model: each set remembers the full line address it holds.
  bit          m_valid [NSETS];
  logic [26:0] m_line  [NSETS];
  int          m_out;
  int          m_hits;
  int          m_misses;

  logic        e_av;
  logic        e_hm;
  logic [26:0] e_addr;
  logic [4:0]  e_lat;
  logic [1:0]  e_scb;
  logic [2:0]  e_warp;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("addr_valid", 32'(bus.addr_valid), 32'(e_av));
    check_val("hit_missbar", 32'(bus.cle_hit_missbar), 32'(e_hm));
    check_val("cle_addr", 32'(bus.cle_addr), 32'(e_addr));
    check_val("cle_latency", 32'(bus.cle_latency), 32'(e_lat));
    check_val("scbID", 32'(bus.scbID), 32'(e_scb));
    check_val("warpID", 32'(bus.warpID), 32'(e_warp));
    check_val("hit_count", 32'(hit_count), 32'(m_hits));
    check_val("miss_count", 32'(miss_count), 32'(m_misses));
  endtask

  task automatic model_clear();
    for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
    m_out = 0; m_hits = 0; m_misses = 0;
    e_av = 0; e_hm = 0; e_addr = '0; e_lat = '0; e_scb = '0; e_warp = '0;
  endtask

  // Called right after a posedge; applies one cycle of stimulus and checks the result.
  task automatic step(input bit v, input logic [26:0] a, input logic [1:0] s,
                      input logic [2:0] w, input bit fb, input logic [26:0] fa);
    bit acc;
    bit hit;
    int idx;
    bus.req_valid          = v;
    bus.req_addr           = a;
    bus.req_scbID          = s;
    bus.req_warpID         = w;
    bus.neg_feedback_valid = fb;
    bus.neg_feedback_addr  = fa;
    #1;
    check_val("req_ready", 32'(bus.req_ready), 32'(m_out != DEPTH));
    acc = v && (m_out != DEPTH);
    idx = int'(a) % NSETS;
    hit = m_valid[idx] && (m_line[idx] == a);
    e_av = acc;
    if (acc) begin
      e_hm = hit; e_addr = a; e_lat = hit ? 5'd0 : 5'd20; e_scb = s; e_warp = w;
      if (hit) m_hits = (m_hits == 65535) ? m_hits : m_hits + 1;
      else     m_misses = (m_misses == 65535) ? m_misses : m_misses + 1;
    end
    if (acc && !hit) m_out++;
    if (fb && m_out > 0) m_out--;
    if (fb) begin
      m_valid[int'(fa) % NSETS] = 1'b1;
      m_line[int'(fa) % NSETS]  = fa;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset(input bit v, input logic [26:0] a);
    rst = 1'b1;
    bus.req_valid = v;
    bus.req_addr = a;
    bus.neg_feedback_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    model_clear();
    check_outputs();
    check_val("rst_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic idle();
    step(0, '0, '0, '0, 0, '0);
  endtask

  logic [26:0] ra;
  logic [26:0] rf;

  initial begin
    bus.req_valid = 0; bus.req_addr = '0; bus.req_scbID = '0; bus.req_warpID = '0;
    bus.neg_feedback_valid = 0; bus.neg_feedback_addr = '0;
    model_clear();
    do_reset(0, '0);

    // First miss
    step(1, 27'h0000040, 2'd1, 3'd5, 0, '0);
    check_val("first_lat", 32'(bus.cle_latency), 32'd20);
    check_val("first_miss_count", 32'(miss_count), 32'd1);
    // Fill then hit
    step(0, '0, '0, '0, 1, 27'h0000040);
    step(1, 27'h0000040, 2'd1, 3'd5, 0, '0);
    check_val("first_hit", 32'(bus.cle_hit_missbar), 32'd1);
    check_val("first_hit_count", 32'(hit_count), 32'd1);

    // Fill the MSHR budget
    for (int i = 0; i < 8; i++) step(1, 27'h0001000 + 27'(i), 2'(i), 3'(i), 0, '0);
    check_val("full_ready", 32'(bus.req_ready), 32'd0);
    step(1, 27'h0002000, 2'd2, 3'd3, 0, '0);
    check_val("held_not_acc", 32'(bus.addr_valid), 32'd0);
    step(1, 27'h0002000, 2'd2, 3'd3, 1, 27'h0001000);
    check_val("ready_after_fb", 32'(bus.req_ready), 32'd1);
    // 9th accepted alongside a feedback with 7 outstanding
    step(1, 27'h0002000, 2'd2, 3'd3, 1, 27'h0001001);
    check_val("ninth_acc", 32'(bus.addr_valid), 32'd1);
    check_val("ready_7_same_edge", 32'(bus.req_ready), 32'd1);

    // Same-edge lookup and fill to the same line
    step(1, 27'h0000080, 2'd0, 3'd1, 1, 27'h0000080);
    check_val("same_edge_miss", 32'(bus.cle_hit_missbar), 32'd0);
    step(1, 27'h0000080, 2'd0, 3'd1, 0, '0);
    check_val("repeat_hit", 32'(bus.cle_hit_missbar), 32'd1);

    // Conflict eviction
    step(0, '0, '0, '0, 1, 27'h0000040);
    step(0, '0, '0, '0, 1, 27'h0001040);
    step(1, 27'h0000040, 2'd3, 3'd7, 0, '0);
    check_val("conflict_miss", 32'(bus.cle_hit_missbar), 32'd0);
    step(1, 27'h0001040, 2'd3, 3'd7, 0, '0);
    check_val("conflict_hit", 32'(bus.cle_hit_missbar), 32'd1);

    // Reset mid-stream with a request pending
    do_reset(1, 27'h0001040);
    step(1, 27'h0001040, 2'd1, 3'd2, 0, '0);
    check_val("post_rst_miss", 32'(bus.cle_hit_missbar), 32'd0);

    // Randomized traffic over a small pool of sets and tags
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) ra = 27'($urandom);
      else ra = 27'(($urandom_range(0, 2) << 6) | $urandom_range(0, 3));
      rf = 27'(($urandom_range(0, 2) << 6) | $urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) begin
        do_reset(1'($urandom_range(0, 1)), ra);
      end else begin
        step(1'($urandom_range(0, 3) != 0), ra, 2'($urandom), 3'($urandom),
             (m_out > 0) && ($urandom_range(0, 2) == 0), rf);
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
